// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants: datapath width, zero-register index and the
// operation encodings used by the multiply/divide unit.
package legv8_pkg;

   localparam int unsigned DATA_W = 64;
   localparam logic [4:0]  XZR    = 5'd31;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULH = 2'b01;
   localparam logic [1:0] OP_UDIV  = 2'b10;
   localparam logic [1:0] OP_SDIV  = 2'b11;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply (MUL/UMULH) and restoring divide (UDIV/SDIV).
// One bit-step per cycle through a shared double-width shift register.
module mul_div_unit
   import legv8_pkg::*;
#(
   parameter int unsigned WIDTH      = DATA_W,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      operand_a,
   input  logic [WIDTH-1:0]      operand_b,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic [REG_ADDR_W-1:0] result_reg,
   output logic                  REG_WRITE_OUT
);

   localparam int unsigned       CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]        opnd_q, opnd_d;
   logic [1:0]              op_q, op_d;
   logic                    neg_q, neg_d;
   logic [REG_ADDR_W-1:0]   dest_q, dest_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    wr_q, wr_d;
   logic [WIDTH-1:0]        result_q, result_d;
   logic [REG_ADDR_W-1:0]   result_reg_q, result_reg_d;

   logic                    accept, in_div, div_zero, src_div;
   logic [WIDTH-1:0]        abs_a, abs_b, src_opnd, quo, final_val;
   logic [2*WIDTH-1:0]      src_acc, step_acc;
   logic [WIDTH:0]          rem, sum;

   // Datapath: the accept edge performs the first bit-step straight from the inputs.
   always_comb begin
      accept   = start && (state_q != StRun);
      in_div   = op[1];
      abs_a    = (op == OP_SDIV && operand_a[WIDTH-1]) ? -operand_a : operand_a;
      abs_b    = (op == OP_SDIV && operand_b[WIDTH-1]) ? -operand_b : operand_b;
      div_zero = in_div && (operand_b == '0);
      src_acc  = accept ? {{WIDTH{1'b0}}, abs_a} : acc_q;
      src_opnd = accept ? abs_b : opnd_q;
      src_div  = accept ? in_div : op_q[1];

      rem = {src_acc[2*WIDTH-1:WIDTH], src_acc[WIDTH-1]};
      quo = {src_acc[WIDTH-2:0], 1'b0};
      if (rem >= {1'b0, src_opnd}) begin
         rem    = rem - {1'b0, src_opnd};
         quo[0] = 1'b1;
      end
      sum = {1'b0, src_acc[2*WIDTH-1:WIDTH]} + (src_acc[0] ? {1'b0, src_opnd} : '0);
      step_acc = src_div ? {rem[WIDTH-1:0], quo} : {sum, src_acc[WIDTH-1:1]};

      case (op_q)
         OP_UMULH: final_val = acc_q[2*WIDTH-1:WIDTH];
         OP_SDIV:  final_val = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         default:  final_val = acc_q[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      opnd_d       = opnd_q;
      op_d         = op_q;
      neg_d        = neg_q;
      dest_d       = dest_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      wr_d         = 1'b0;
      result_d     = result_q;
      result_reg_d = result_reg_q;

      case (state_q)
         StIdle, StFinish: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            if (accept) begin
               state_d = StRun;
               busy_d  = 1'b1;
               op_d    = op;
               dest_d  = dest_reg;
               neg_d   = (op == OP_SDIV) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
               opnd_d  = abs_b;
               // Divide by zero skips the iterations: zero quotient, finish next edge.
               if (div_zero) begin
                  acc_d = '0;
                  cnt_d = CntLast;
               end else begin
                  acc_d = step_acc;
                  cnt_d = '0;
               end
            end
         end
         StRun: begin
            if (cnt_q == CntLast) begin
               state_d      = StFinish;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               wr_d         = (dest_q != REG_ADDR_W'(XZR));
               result_d     = final_val;
               result_reg_d = dest_q;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         acc_q        <= '0;
         opnd_q       <= '0;
         op_q         <= OP_MUL;
         neg_q        <= 1'b0;
         dest_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wr_q         <= 1'b0;
         result_q     <= '0;
         result_reg_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         opnd_q       <= opnd_d;
         op_q         <= op_d;
         neg_q        <= neg_d;
         dest_q       <= dest_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         wr_q         <= wr_d;
         result_q     <= result_d;
         result_reg_q <= result_reg_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign result        = result_q;
   assign result_reg    = result_reg_q;
   assign REG_WRITE_OUT = wr_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latencies and write strobe.
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [63:0] operand_a;
   logic [63:0] operand_b;
   logic [4:0]  dest_reg;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic [4:0]  result_reg;
   logic        reg_write;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;

   mul_div_unit #(.WIDTH(64), .REG_ADDR_W(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .op            (op),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .dest_reg      (dest_reg),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .result_reg    (result_reg),
      .REG_WRITE_OUT (reg_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request at the falling edge, accepted on the next rising edge.
   task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; dest_reg = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      operand_a = 64'hDEAD_BEEF_0BAD_F00D;
      operand_b = 64'h0123_4567_89AB_CDEF;
      dest_reg  = 5'd17;
   endtask

   // Counts rising edges until done, bounded.
   task automatic wait_done(output int c);
      c = 0;
      while (done !== 1'b1 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
   endtask

   task automatic check_done(input string tag, input logic [63:0] res, input logic [4:0] rd,
                             input logic wr);
      check({tag, ".done"}, 64'(done), 64'd1);
      check({tag, ".busy"}, 64'(busy), 64'd0);
      check({tag, ".result"}, result, res);
      check({tag, ".result_reg"}, 64'(result_reg), 64'(rd));
      check({tag, ".wr"}, 64'(reg_write), 64'(wr));
      @(posedge clk);
      #1;
      check({tag, ".done_1cyc"}, 64'(done), 64'd0);
      check({tag, ".wr_1cyc"}, 64'(reg_write), 64'd0);
      check({tag, ".hold"}, result, res);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00;
      operand_a = '0; operand_b = '0; dest_reg = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.wr", 64'(reg_write), 64'd0);
      check("rst.result", result, 64'd0);
      check("rst.result_reg", 64'(result_reg), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(2'b00, 64'd7, 64'd6, 5'd3);
      check("mul7x6.busy", 64'(busy), 64'd1);
      wait_done(cyc);
      check("mul7x6.latency", 64'(cyc), 64'd64);
      check_done("mul7x6", 64'd42, 5'd3, 1'b1);

      issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
      wait_done(cyc);
      check_done("umulh_max", 64'hFFFF_FFFF_FFFF_FFFE, 5'd10, 1'b1);

      issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11);
      wait_done(cyc);
      check_done("mul_max", 64'd1, 5'd11, 1'b1);

      issue(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12);
      wait_done(cyc);
      check("sdiv_m7_2.latency", 64'(cyc), 64'd64);
      check_done("sdiv_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 5'd12, 1'b1);

      issue(2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13);
      wait_done(cyc);
      check_done("sdiv_min_m1", 64'h8000_0000_0000_0000, 5'd13, 1'b1);

      issue(2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14);
      wait_done(cyc);
      check_done("sdiv_m100_m7", 64'd14, 5'd14, 1'b1);

      issue(2'b10, 64'd100, 64'd7, 5'd15);
      wait_done(cyc);
      check_done("udiv100_7", 64'd14, 5'd15, 1'b1);

      issue(2'b10, 64'd5, 64'd0, 5'd9);
      check("udiv0.busy", 64'(busy), 64'd1);
      wait_done(cyc);
      check("udiv0.latency", 64'(cyc), 64'd1);
      check_done("udiv0", 64'd0, 5'd9, 1'b1);

      issue(2'b10, 64'd5, 64'd0, 5'd31);
      wait_done(cyc);
      check("udiv0_xzr.latency", 64'(cyc), 64'd1);
      check_done("udiv0_xzr", 64'd0, 5'd31, 1'b0);

      // A second start ten cycles in must be dropped.
      issue(2'b00, 64'd11, 64'd13, 5'd4);
      repeat (10) @(posedge clk);
      @(negedge clk);
      op = 2'b00; operand_a = 64'd2; operand_b = 64'd2; dest_reg = 5'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ignored.busy", 64'(busy), 64'd1);
      wait_done(cyc);
      check("ignored.latency", 64'(11 + cyc), 64'd64);
      check("ignored.result", result, 64'd143);
      check("ignored.result_reg", 64'(result_reg), 64'd4);
      check("ignored.wr", 64'(reg_write), 64'd1);

      // Back-to-back: start during the done cycle.
      @(negedge clk);
      op = 2'b10; operand_a = 64'hFFFF_FFFF_FFFF_FFFF; operand_b = 64'h10; dest_reg = 5'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b.busy", 64'(busy), 64'd1);
      check("b2b.done_drop", 64'(done), 64'd0);
      wait_done(cyc);
      check("b2b.latency", 64'(cyc + 1), 64'd65);
      check_done("b2b", 64'h0FFF_FFFF_FFFF_FFFF, 5'd5, 1'b1);

      // Asynchronous abort mid-divide.
      issue(2'b10, 64'd1000, 64'd3, 5'd6);
      repeat (19) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(done), 64'd0);
      check("abort.result", result, 64'd0);
      check("abort.wr", 64'(reg_write), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort.wr_held", 64'(reg_write), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'b00, 64'd3, 64'd5, 5'd2);
      wait_done(cyc);
      check("post_abort.latency", 64'(cyc), 64'd64);
      check_done("post_abort", 64'd15, 5'd2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
